// File: rtl/l1_l2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : l1_l2_pkg
// Brief   : Shared widths and enums for the L1I/L1D -> L2 request arbiter.
// Revision: 1.0  initial release
// ============================================================================
package l1_l2_pkg;

  localparam int TAG_W   = 18;
  localparam int INDEX_W = 8;
  localparam int LINE_W  = 512;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_I    = 2'd1,
    ST_GNT_D_WR = 2'd2,
    ST_GNT_D_RD = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;

endpackage
`default_nettype wire

// File: rtl/l1_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : l1_l2_arbiter
// Brief   : Round-robin sequential arbiter sharing the L2 port between L1I and L1D.
// Revision: 1.0  initial release
// ============================================================================
module l1_l2_arbiter #(
  parameter int TAG_W       = l1_l2_pkg::TAG_W,
  parameter int INDEX_W     = l1_l2_pkg::INDEX_W,
  parameter int LINE_W      = l1_l2_pkg::LINE_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               read_L1I_L2,
  input  logic [TAG_W-1:0]   tag_L1I_L2,
  input  logic [INDEX_W-1:0] index_L1I_L2,
  input  logic               read_L1D_L2,
  input  logic               write_L1D_L2,
  input  logic [TAG_W-1:0]   tag_L1D_L2,
  input  logic [INDEX_W-1:0] index_L1D_L2,
  input  logic [TAG_W-1:0]   write_tag_L1D_L2,
  input  logic [INDEX_W-1:0] write_index_L1D_L2,
  input  logic [LINE_W-1:0]  write_data_L1D_L2,
  input  logic               ready_L2_L1,
  output logic               read_L1_L2,
  output logic               write_L1_L2,
  output logic [TAG_W-1:0]   tag_L1_L2,
  output logic [INDEX_W-1:0] index_L1_L2,
  output logic [LINE_W-1:0]  write_data_L1_L2,
  output logic               ready_L2_L1I,
  output logic               ready_L2_L1D,
  output logic               timeout_err
);
  import l1_l2_pkg::*;

  // Counter only needs to reach TIMEOUT_CYC-1; it saturates there.
  localparam int              WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = (TIMEOUT_CYC > 1) ? WD_W'(TIMEOUT_CYC - 1) : '0;

  arb_state_t      state_q, state_d;
  gnt_t            last_gnt_q, last_gnt_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_err_q, timeout_err_d;
  logic            pend_i, pend_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      last_gnt_q    <= GNT_D;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    last_gnt_d       = last_gnt_q;
    wdog_d           = wdog_q;
    timeout_err_d    = timeout_err_q;
    read_L1_L2       = 1'b0;
    write_L1_L2      = 1'b0;
    tag_L1_L2        = '0;
    index_L1_L2      = '0;
    write_data_L1_L2 = '0;
    ready_L2_L1I     = 1'b0;
    ready_L2_L1D     = 1'b0;
    pend_i           = read_L1I_L2;
    pend_d           = read_L1D_L2 | write_L1D_L2;

    case (state_q)
      ST_IDLE: begin
        // Ties go to whoever did not win last; reset value D makes I win first.
        if (pend_i && (!pend_d || (last_gnt_q != GNT_I))) begin
          state_d    = ST_GNT_I;
          last_gnt_d = GNT_I;
        end else if (pend_d) begin
          state_d    = write_L1D_L2 ? ST_GNT_D_WR : ST_GNT_D_RD;
          last_gnt_d = GNT_D;
        end
      end
      ST_GNT_I: begin
        read_L1_L2  = 1'b1;
        tag_L1_L2   = tag_L1I_L2;
        index_L1_L2 = index_L1I_L2;
        if (ready_L2_L1) begin
          ready_L2_L1I = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_GNT_D_WR: begin
        write_L1_L2      = 1'b1;
        tag_L1_L2        = write_tag_L1D_L2;
        index_L1_L2      = write_index_L1D_L2;
        write_data_L1_L2 = write_data_L1D_L2;
        // A victim write-back followed by a fill reports completion only once, after the fill.
        if (ready_L2_L1) begin
          if (read_L1D_L2) begin
            state_d = ST_GNT_D_RD;
          end else begin
            ready_L2_L1D = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_GNT_D_RD: begin
        read_L1_L2  = 1'b1;
        tag_L1_L2   = tag_L1D_L2;
        index_L1_L2 = index_L1D_L2;
        if (ready_L2_L1) begin
          ready_L2_L1D = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_IDLE) || (state_d != state_q)) begin
      wdog_d = '0;
    end else if (wdog_q != WD_MAX) begin
      wdog_d = wdog_q + WD_W'(1);
    end

    if ((TIMEOUT_CYC != 0) && (state_q != ST_IDLE) && (wdog_q == WD_MAX) && !ready_L2_L1) begin
      timeout_err_d = 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
